// File: rtl/pipa_moding_gen_pkg.sv
// Shared types and helpers for the PIPA moding stimulus generator.
package pipa_sim_pkg;

  localparam int PIPA_CYCLE_LEN_DEF = 6;
  localparam int PIPA_ACC_W_DEF     = 8;

  typedef enum logic [1:0] {MOD_BAL, MOD_PLUS, MOD_MINUS} moding_t;

  // Signed add clamped to the range of a w-bit two's complement value.
  function automatic int sat_add(input int a, input int b, input int w);
    longint s;
    longint hi;
    longint lo;
    s  = longint'(a) + longint'(b);
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -(longint'(1) <<< (w - 1));
    if (s > hi) return int'(hi);
    if (s < lo) return int'(lo);
    return int'(s);
  endfunction

endpackage

// File: rtl/pipa_moding_gen_axis.sv
// One PIPA channel: pending net-count, cycle moding latch and PIPDAT output gating.
// force_on is only driven high in builds with PIPA_FAIL_INJECT_EN.
module pipa_axis
  import pipa_sim_pkg::*;
#(
  parameter int CYCLE_LEN = PIPA_CYCLE_LEN_DEF,
  parameter int ACC_W     = PIPA_ACC_W_DEF,
  parameter int PH_W      = $clog2(CYCLE_LEN)
) (
  input  logic                    SIM_CLK,
  input  logic                    SIM_RST,
  input  logic [PH_W-1:0]         phase,
  input  logic                    wrap,
  input  logic                    load_hit,
  input  logic signed [ACC_W-1:0] load_value,
  input  logic                    PIPDAT,
  input  logic                    force_on,
  output logic                    pipa_p,
  output logic                    pipa_m,
  output logic                    pending_nz
);

  localparam int H = CYCLE_LEN / 2;

  moding_t                 mode;
  logic signed [ACC_W-1:0] pending;
  logic signed [ACC_W-1:0] pending_nxt;
  logic [PH_W-1:0]         plus_len;
  logic                    plus_slot;
  int                      sgn;

  // A latch consumes one count toward zero; a coincident load is folded in before clamping.
  always_comb begin
    sgn = 0;
    if (wrap && (pending > 0))      sgn = 1;
    else if (wrap && (pending < 0)) sgn = -1;
    pending_nxt = ACC_W'(sat_add(int'(pending) - sgn,
                                 load_hit ? int'(load_value) : 0, ACC_W));
  end

  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      pending <= '0;
      mode    <= MOD_BAL;
    end else begin
      pending <= pending_nxt;
      if (wrap) begin
        if (pending > 0)      mode <= MOD_PLUS;
        else if (pending < 0) mode <= MOD_MINUS;
        else                  mode <= MOD_BAL;
      end
    end
  end

  always_comb begin
    unique case (mode)
      MOD_PLUS:  plus_len = PH_W'(H + 1);
      MOD_MINUS: plus_len = PH_W'(H - 1);
      default:   plus_len = PH_W'(H);
    endcase
  end

  assign plus_slot  = (phase < plus_len);
  assign pipa_p     = PIPDAT & (plus_slot | force_on);
  assign pipa_m     = PIPDAT & (~plus_slot | force_on);
  assign pending_nz = |pending;

endmodule

// File: rtl/pipa_moding_gen.sv
// PIPA pulse-pair stimulus generator: PIPASW edge detect, phase counter and load decode.
// PIPA_FAIL_INJECT_EN adds fail_force for driving illegal simultaneous +/- pulses.
module pipa_moding_gen
  import pipa_sim_pkg::*;
#(
  parameter int N_AXES    = 3,
  parameter int CYCLE_LEN = PIPA_CYCLE_LEN_DEF,
  parameter int ACC_W     = PIPA_ACC_W_DEF,
  localparam int AX_W     = (N_AXES > 1) ? $clog2(N_AXES) : 1,
  localparam int PH_W     = $clog2(CYCLE_LEN)
) (
  input  logic                    SIM_CLK,
  input  logic                    SIM_RST,
  input  logic                    PIPASW,
  input  logic                    PIPDAT,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [AX_W-1:0]         load_axis,
  input  logic signed [ACC_W-1:0] load_value,
  output logic [N_AXES-1:0]       pipa_p,
  output logic [N_AXES-1:0]       pipa_m,
  output logic [PH_W-1:0]         phase,
`ifdef PIPA_FAIL_INJECT_EN
  input  logic [N_AXES-1:0]       fail_force,
`endif
  output logic [N_AXES-1:0]       pending_nz
);

  logic              sw_q;
  logic              sw_rise;
  logic              wrap;
  logic              load_fire;
  logic [N_AXES-1:0] force_vec;

`ifdef PIPA_FAIL_INJECT_EN
  assign force_vec = fail_force;
`else
  assign force_vec = '0;
`endif

  assign load_ready = ~SIM_RST;
  assign load_fire  = load_valid & load_ready;
  assign sw_rise    = PIPASW & ~sw_q;
  assign wrap       = sw_rise && (phase == PH_W'(CYCLE_LEN - 1));

  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      sw_q  <= 1'b0;
      phase <= '0;
    end else begin
      sw_q <= PIPASW;
      if (sw_rise) phase <= wrap ? '0 : phase + 1'b1;
    end
  end

  for (genvar i = 0; i < N_AXES; i++) begin : g_axis
    pipa_axis #(
      .CYCLE_LEN(CYCLE_LEN),
      .ACC_W    (ACC_W),
      .PH_W     (PH_W)
    ) u_axis (
      .SIM_CLK   (SIM_CLK),
      .SIM_RST   (SIM_RST),
      .phase     (phase),
      .wrap      (wrap),
      .load_hit  (load_fire && (load_axis == AX_W'(i))),
      .load_value(load_value),
      .PIPDAT    (PIPDAT),
      .force_on  (force_vec[i]),
      .pipa_p    (pipa_p[i]),
      .pipa_m    (pipa_m[i]),
      .pending_nz(pending_nz[i])
    );
  end

endmodule

// File: tb/tb_pipa_moding_gen.sv
// Directed bench for pipa_moding_gen: default 6-sample build plus an 8-sample instance.
module tb_pipa_moding_gen;

  logic              SIM_CLK = 1'b0;
  logic              SIM_RST;
  logic              PIPASW;
  logic              PIPDAT;
  logic              load_valid;
  logic              load_valid8;
  logic [1:0]        load_axis;
  logic signed [7:0] load_value;
  logic              load_ready;
  logic              load_ready8;
  logic [2:0]        pipa_p, pipa_m, pending_nz, phase;
  logic [2:0]        pipa_p8, pipa_m8, pending_nz8, phase8;
`ifdef PIPA_FAIL_INJECT_EN
  logic [2:0]        fail_force;
  logic [2:0]        fail_force8;
`endif

  int checks = 0;
  int errors = 0;

  always #5 SIM_CLK = ~SIM_CLK;

  pipa_moding_gen dut (
    .SIM_CLK   (SIM_CLK),
    .SIM_RST   (SIM_RST),
    .PIPASW    (PIPASW),
    .PIPDAT    (PIPDAT),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_axis (load_axis),
    .load_value(load_value),
    .pipa_p    (pipa_p),
    .pipa_m    (pipa_m),
    .phase     (phase),
`ifdef PIPA_FAIL_INJECT_EN
    .fail_force(fail_force),
`endif
    .pending_nz(pending_nz)
  );

  pipa_moding_gen #(.CYCLE_LEN(8)) dut8 (
    .SIM_CLK   (SIM_CLK),
    .SIM_RST   (SIM_RST),
    .PIPASW    (PIPASW),
    .PIPDAT    (PIPDAT),
    .load_valid(load_valid8),
    .load_ready(load_ready8),
    .load_axis (load_axis),
    .load_value(load_value),
    .pipa_p    (pipa_p8),
    .pipa_m    (pipa_m8),
    .phase     (phase8),
`ifdef PIPA_FAIL_INJECT_EN
    .fail_force(fail_force8),
`endif
    .pending_nz(pending_nz8)
  );

  task automatic tick();
    @(posedge SIM_CLK);
    #1;
  endtask

  task automatic pulse_sw();
    PIPASW = 1'b1;
    tick();
    PIPASW = 1'b0;
    tick();
  endtask

  task automatic do_load(input logic [1:0] ax, input logic signed [7:0] val);
    load_axis  = ax;
    load_value = val;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic test_reset();
    SIM_RST = 1'b1; PIPASW = 1'b0; PIPDAT = 1'b0;
    load_valid = 1'b0; load_valid8 = 1'b0; load_axis = '0; load_value = '0;
`ifdef PIPA_FAIL_INJECT_EN
    fail_force = '0; fail_force8 = '0;
`endif
    tick(); tick();
    checks++;
    if (load_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %b expected 0", load_ready); end
    SIM_RST = 1'b0;
    #1;
    checks++;
    if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_high: got %b expected 1", load_ready); end
    checks++;
    if (phase !== 3'd0) begin errors++; $display("FAIL reset_phase: got %0d expected 0", phase); end
    checks++;
    if (pending_nz !== 3'b000) begin errors++; $display("FAIL reset_pending_nz: got %b expected 000", pending_nz); end
    checks++;
    if (pipa_p !== 3'b000 || pipa_m !== 3'b000)
      begin errors++; $display("FAIL reset_outputs_gated: got p=%b m=%b expected 000/000", pipa_p, pipa_m); end
  endtask

  task automatic test_balanced();
    int net[3];
    net = '{0, 0, 0};
    for (int k = 0; k < 12; k++) begin
      logic [2:0] ep;
      ep = ((k % 6) < 3) ? 3'b111 : 3'b000;
      PIPDAT = 1'b1;
      #2;
      checks++;
      if (phase !== 3'(k % 6)) begin errors++; $display("FAIL bal_phase k=%0d: got %0d expected %0d", k, phase, k % 6); end
      checks++;
      if (pipa_p !== ep || pipa_m !== ~ep)
        begin errors++; $display("FAIL bal_slots k=%0d: got p=%b m=%b expected p=%b m=%b", k, pipa_p, pipa_m, ep, ~ep); end
      for (int a = 0; a < 3; a++) net[a] += int'(pipa_p[a]) - int'(pipa_m[a]);
      PIPDAT = 1'b0;
      pulse_sw();
    end
    for (int a = 0; a < 3; a++) begin
      checks++;
      if (net[a] !== 0) begin errors++; $display("FAIL bal_net axis%0d: got %0d expected 0", a, net[a]); end
    end
  endtask

  task automatic test_load_plus();
    int net1;
    net1 = 0;
    pulse_sw();
    load_axis = 2'd1; load_value = 8'sd2; load_valid = 1'b1;
    checks++;
    if (load_ready !== 1'b1) begin errors++; $display("FAIL load_ready: got %b expected 1", load_ready); end
    tick();
    load_valid = 1'b0;
    checks++;
    if (pending_nz !== 3'b010) begin errors++; $display("FAIL plus_nz_load: got %b expected 010", pending_nz); end
    for (int c = 0; c < 4; c++) begin
      logic [2:0] exp_nz;
      for (int ph = (c == 0) ? 1 : 0; ph < 6; ph++) begin
        logic [2:0] ep;
        for (int a = 0; a < 3; a++) ep[a] = (ph < ((a == 1 && (c == 1 || c == 2)) ? 4 : 3));
        PIPDAT = 1'b1;
        #2;
        checks++;
        if (pipa_p !== ep || pipa_m !== ~ep)
          begin errors++; $display("FAIL plus_slots c=%0d ph=%0d: got p=%b m=%b expected p=%b m=%b", c, ph, pipa_p, pipa_m, ep, ~ep); end
        if (c == 1 || c == 2) net1 += int'(pipa_p[1]) - int'(pipa_m[1]);
        PIPDAT = 1'b0;
        pulse_sw();
      end
      exp_nz = (c == 0) ? 3'b010 : 3'b000;
      checks++;
      if (pending_nz !== exp_nz) begin errors++; $display("FAIL plus_nz c=%0d: got %b expected %b", c, pending_nz, exp_nz); end
    end
    checks++;
    if (net1 !== 4) begin errors++; $display("FAIL plus_net axis1: got %0d expected 4", net1); end
  endtask

  task automatic test_wrap_load();
    do_load(2'd0, 8'sd1);
    for (int i = 0; i < 5; i++) pulse_sw();
    load_axis = 2'd0; load_value = 8'sd3; load_valid = 1'b1; PIPASW = 1'b1;
    tick();
    load_valid = 1'b0; PIPASW = 1'b0;
    tick();
    checks++;
    if (phase !== 3'd0) begin errors++; $display("FAIL wrap_phase: got %0d expected 0", phase); end
    checks++;
    if (pending_nz !== 3'b001) begin errors++; $display("FAIL wrap_nz: got %b expected 001", pending_nz); end
    for (int c = 0; c < 5; c++) begin
      int cnt;
      cnt = 0;
      for (int ph = 0; ph < 6; ph++) begin
        PIPDAT = 1'b1;
        #2;
        cnt += int'(pipa_p[0]);
        PIPDAT = 1'b0;
        pulse_sw();
      end
      checks++;
      if (cnt !== ((c < 4) ? 4 : 3)) begin errors++; $display("FAIL wrap_plus_count c=%0d: got %0d expected %0d", c, cnt, (c < 4) ? 4 : 3); end
    end
  endtask

  task automatic test_saturation();
    do_load(2'd2, 8'sd127);
    do_load(2'd2, 8'sd127);
    checks++;
    if (pending_nz !== 3'b100) begin errors++; $display("FAIL sat_pos_nz: got %b expected 100", pending_nz); end
    do_load(2'd2, -8'sd127);
    checks++;
    if (pending_nz !== 3'b000) begin errors++; $display("FAIL sat_pos_clamp: got %b expected 000", pending_nz); end
    do_load(2'd2, -8'sd128);
    do_load(2'd2, -8'sd128);
    do_load(2'd2, 8'sd127);
    do_load(2'd2, 8'sd1);
    checks++;
    if (pending_nz !== 3'b000) begin errors++; $display("FAIL sat_neg_clamp: got %b expected 000", pending_nz); end
    do_load(2'd3, 8'sd5);
    checks++;
    if (pending_nz !== 3'b000) begin errors++; $display("FAIL load_axis_oob: got %b expected 000", pending_nz); end
  endtask

  task automatic test_sw_edges();
    PIPASW = 1'b1;
    tick(); tick(); tick();
    PIPASW = 1'b0;
    tick();
    checks++;
    if (phase !== 3'd1) begin errors++; $display("FAIL sw_held: got %0d expected 1", phase); end
    PIPASW = 1'b1;
    #3;
    PIPASW = 1'b0;
    tick(); tick();
    checks++;
    if (phase !== 3'd1) begin errors++; $display("FAIL sw_glitch: got %0d expected 1", phase); end
    for (int i = 0; i < 5; i++) pulse_sw();
    checks++;
    if (phase !== 3'd0) begin errors++; $display("FAIL sw_wrap: got %0d expected 0", phase); end
  endtask

  task automatic test_reset_mid();
    do_load(2'd0, 8'sd5);
    for (int i = 0; i < 3; i++) pulse_sw();
    SIM_RST = 1'b1;
    tick();
    PIPDAT = 1'b1;
    #1;
    checks++;
    if (phase !== 3'd0 || pending_nz !== 3'b000 || load_ready !== 1'b0)
      begin errors++; $display("FAIL rst_mid_state: got phase=%0d nz=%b ready=%b expected 0/000/0", phase, pending_nz, load_ready); end
    checks++;
    if (pipa_p !== 3'b111 || pipa_m !== 3'b000)
      begin errors++; $display("FAIL rst_mid_slots: got p=%b m=%b expected 111/000", pipa_p, pipa_m); end
    PIPDAT = 1'b0;
    SIM_RST = 1'b0;
    for (int c = 0; c < 2; c++) begin
      int cnt;
      cnt = 0;
      for (int ph = 0; ph < 6; ph++) begin
        PIPDAT = 1'b1;
        #2;
        cnt += int'(pipa_p[0]);
        PIPDAT = 1'b0;
        pulse_sw();
      end
      checks++;
      if (cnt !== 3) begin errors++; $display("FAIL rst_mid_balanced c=%0d: got %0d expected 3", c, cnt); end
    end
  endtask

  task automatic test_cycle8();
    SIM_RST = 1'b1;
    tick();
    SIM_RST = 1'b0;
    load_axis = 2'd0; load_value = -8'sd1; load_valid8 = 1'b1;
    tick();
    load_valid8 = 1'b0;
    checks++;
    if (pending_nz8 !== 3'b001) begin errors++; $display("FAIL c8_nz: got %b expected 001", pending_nz8); end
    for (int c = 0; c < 3; c++) begin
      int cp, cm;
      cp = 0; cm = 0;
      for (int ph = 0; ph < 8; ph++) begin
        PIPDAT = 1'b1;
        #2;
        checks++;
        if (phase8 !== 3'(ph)) begin errors++; $display("FAIL c8_phase c=%0d: got %0d expected %0d", c, phase8, ph); end
        cp += int'(pipa_p8[0]);
        cm += int'(pipa_m8[0]);
        PIPDAT = 1'b0;
        pulse_sw();
      end
      checks++;
      if (cp !== ((c == 1) ? 3 : 4) || cm !== ((c == 1) ? 5 : 4))
        begin errors++; $display("FAIL c8_counts c=%0d: got p=%0d m=%0d expected p=%0d m=%0d", c, cp, cm, (c == 1) ? 3 : 4, (c == 1) ? 5 : 4); end
    end
  endtask

`ifdef PIPA_FAIL_INJECT_EN
  task automatic test_fail_inject();
    fail_force = 3'b100;
    for (int ph = 0; ph < 6; ph++) begin
      logic [1:0] ep;
      ep = (ph < 3) ? 2'b11 : 2'b00;
      PIPDAT = 1'b1;
      #2;
      checks++;
      if (phase !== 3'(ph)) begin errors++; $display("FAIL inj_phase: got %0d expected %0d", phase, ph); end
      checks++;
      if (pipa_p[2] !== 1'b1 || pipa_m[2] !== 1'b1)
        begin errors++; $display("FAIL inj_axis2 ph=%0d: got p=%b m=%b expected 1/1", ph, pipa_p[2], pipa_m[2]); end
      checks++;
      if (pipa_p[1:0] !== ep || pipa_m[1:0] !== ~ep)
        begin errors++; $display("FAIL inj_others ph=%0d: got p=%b m=%b expected p=%b m=%b", ph, pipa_p[1:0], pipa_m[1:0], ep, ~ep); end
      PIPDAT = 1'b0;
      pulse_sw();
    end
    fail_force = 3'b000;
  endtask
`endif

  initial begin
    test_reset();
    test_balanced();
    test_load_plus();
    test_wrap_load();
    test_saturation();
    test_sw_edges();
    test_reset_mid();
    test_cycle8();
`ifdef PIPA_FAIL_INJECT_EN
    test_fail_inject();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
